// File: rtl/adxl355_spi_regif.sv
// SPI mode-0 slave and ADXL355-style register file, all in the mems_clk domain.
// SPI pins are oversampled; frames decode into register reads/writes with address auto-increment.
module adxl355_spi_regif #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        mems_clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    input  logic        NVM_BUSY,
    input  logic        FIFO_OVR,
    input  logic        temp_valid,
    input  logic [11:0] temp_in,
    input  logic        xdata_valid,
    input  logic        ydata_valid,
    input  logic        zdata_valid,
    input  logic [19:0] xdata_in,
    input  logic [19:0] ydata_in,
    input  logic [19:0] zdata_in,
    input  logic [7:0]  fifo_data_in,
    input  logic [6:0]  FIFO_ENTRIES_in,
    output logic        fifo_rd_en,
    output logic [2:0]  HPF_CONER,
    output logic [3:0]  ODR_LPF,
    output logic        ACT_EN2,
    output logic        OVR_EN2,
    output logic        FULL_EN2,
    output logic        RDY_EN2,
    output logic        ACT_EN1,
    output logic        OVR_EN1,
    output logic        FULL_EN1,
    output logic        RDY_EN1,
    output logic [1:0]  range,
    output logic        DRDY_OFF,
    output logic        TEMP_OFF,
    output logic        STANDBY
);

    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;

    localparam logic [6:0] RW_FIRST  = 7'h1E;
    localparam logic [6:0] RW_LAST   = 7'h2E;
    localparam logic [6:0] A_STATUS  = 7'h04;
    localparam logic [6:0] A_FIFO    = 7'h11;
    localparam logic [6:0] A_RESET   = 7'h2F;
    localparam int         RW_COUNT  = 17;

    function automatic logic [7:0] rw_default(input logic [4:0] idx);
        logic [7:0] val;
        case (idx)
            5'd11:   val = 8'h60;
            5'd14:   val = 8'h81;
            5'd15:   val = 8'h01;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic       sclk_s, cs_s, mosi_s, sclk_prev;
    logic       sclk_rise, sclk_fall;

    state_t     state, state_next;
    logic [2:0] bit_cnt;
    logic [7:0] rx_sh, rx_byte, tx_sh;
    logic [6:0] addr, addr_next, load_addr;
    logic       byte_done, wr_en, tx_load, pop_req, tx_fifo;

    logic [7:0]  rw_regs [RW_COUNT];
    logic [4:0]  rd_idx, wr_idx;
    logic [7:0]  rd_data, status;
    logic [11:0] temp_reg;
    logic [19:0] x_reg, y_reg, z_reg;
    logic        data_rdy, fifo_full, status_load;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;

    assign rx_byte   = {rx_sh[6:0], mosi_s};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7) && (state != IDLE) && !cs_s;
    // FIFO_DATA is a port, not a memory: bursts keep hitting it
    assign addr_next = (addr == A_FIFO) ? addr : addr + 7'd1;
    assign load_addr = (state == ADDR) ? rx_byte[7:1] : addr_next;
    assign rd_idx    = 5'(load_addr - RW_FIRST);
    assign wr_idx    = 5'(addr - RW_FIRST);

    assign fifo_full   = FIFO_ENTRIES_in >= rw_regs[11][6:0];
    assign status      = {3'b000, NVM_BUSY, 1'b0, FIFO_OVR, fifo_full, data_rdy};
    assign status_load = tx_load && (load_addr == A_STATUS);

    always_comb begin
        rd_data = 8'h00;
        case (load_addr)
            7'h00: rd_data = 8'hAD;
            7'h01: rd_data = 8'h1D;
            7'h02: rd_data = 8'hED;
            7'h03: rd_data = 8'h01;
            7'h04: rd_data = status;
            7'h05: rd_data = {1'b0, FIFO_ENTRIES_in};
            7'h06: rd_data = {4'h0, temp_reg[11:8]};
            7'h07: rd_data = temp_reg[7:0];
            7'h08: rd_data = x_reg[19:12];
            7'h09: rd_data = x_reg[11:4];
            7'h0A: rd_data = {x_reg[3:0], 4'h0};
            7'h0B: rd_data = y_reg[19:12];
            7'h0C: rd_data = y_reg[11:4];
            7'h0D: rd_data = {y_reg[3:0], 4'h0};
            7'h0E: rd_data = z_reg[19:12];
            7'h0F: rd_data = z_reg[11:4];
            7'h10: rd_data = {z_reg[3:0], 4'h0};
            7'h11: rd_data = fifo_data_in;
            default: begin
                if (load_addr >= RW_FIRST && load_addr <= RW_LAST)
                    rd_data = rw_regs[rd_idx];
            end
        endcase
    end

    always_ff @(posedge mems_clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        tx_load    = 1'b0;
        pop_req    = 1'b0;
        if (cs_s) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = ADDR;
                ADDR: begin
                    if (byte_done) begin
                        if (rx_byte[0]) begin
                            state_next = RDATA;
                            tx_load    = 1'b1;
                        end else begin
                            state_next = WDATA;
                        end
                    end
                end
                WDATA: wr_en = byte_done;
                RDATA: begin
                    tx_load = byte_done;
                    // pop once the host starts clocking a FIFO byte, so a prefetch
                    // that is never shifted out does not consume an entry
                    pop_req = sclk_rise && (bit_cnt == 3'd0) && tx_fifo;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge mems_clk) begin
        if (!rst_n) begin
            sclk_sync  <= '0;
            cs_sync    <= '1;
            mosi_sync  <= '0;
            sclk_prev  <= 1'b0;
            bit_cnt    <= 3'd0;
            rx_sh      <= 8'h00;
            tx_sh      <= 8'h00;
            addr       <= 7'h00;
            miso       <= 1'b0;
            tx_fifo    <= 1'b0;
            fifo_rd_en <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev  <= sclk_s;
            fifo_rd_en <= pop_req;
            if (cs_s) begin
                bit_cnt <= 3'd0;
                rx_sh   <= 8'h00;
                miso    <= 1'b0;
                tx_fifo <= 1'b0;
            end else if (state != IDLE) begin
                if (sclk_rise) begin
                    rx_sh   <= rx_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done)
                    addr <= (state == ADDR) ? rx_byte[7:1] : addr_next;
                if (tx_load) begin
                    tx_sh   <= rd_data;
                    tx_fifo <= (load_addr == A_FIFO);
                end else if (sclk_fall && state == RDATA) begin
                    miso  <= tx_sh[7];
                    tx_sh <= {tx_sh[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge mems_clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RW_COUNT; i++) rw_regs[i] <= rw_default(5'(i));
        end else if (wr_en) begin
            if (addr == A_RESET && rx_byte == 8'h52) begin
                for (int i = 0; i < RW_COUNT; i++) rw_regs[i] <= rw_default(5'(i));
            end else if (addr >= RW_FIRST && addr <= RW_LAST) begin
                rw_regs[wr_idx] <= rx_byte;
            end
        end
    end

    always_ff @(posedge mems_clk) begin
        if (!rst_n) begin
            temp_reg <= '0;
            x_reg    <= '0;
            y_reg    <= '0;
            z_reg    <= '0;
            data_rdy <= 1'b0;
        end else begin
            if (temp_valid)  temp_reg <= temp_in;
            if (xdata_valid) x_reg    <= xdata_in;
            if (ydata_valid) y_reg    <= ydata_in;
            if (zdata_valid) z_reg    <= zdata_in;
            if (zdata_valid)      data_rdy <= 1'b1;
            else if (status_load) data_rdy <= 1'b0;
        end
    end

    assign {HPF_CONER, ODR_LPF} = rw_regs[10][6:0];
    assign {ACT_EN2, OVR_EN2, FULL_EN2, RDY_EN2,
            ACT_EN1, OVR_EN1, FULL_EN1, RDY_EN1} = rw_regs[12];
    assign range                        = rw_regs[14][1:0];
    assign {DRDY_OFF, TEMP_OFF, STANDBY} = rw_regs[15][2:0];

endmodule

// File: tb/tb_adxl355_spi_regif.sv
// Bench for adxl355_spi_regif: a bit-banged SPI host drives frames, and a bus monitor
// scores every read byte against an expectation queue filled by the stimulus.
module tb_adxl355_spi_regif;

    logic        mems_clk = 1'b0;
    logic        rst_n, sclk, cs_n, mosi, miso;
    logic        NVM_BUSY, FIFO_OVR, temp_valid;
    logic [11:0] temp_in;
    logic        xdata_valid, ydata_valid, zdata_valid;
    logic [19:0] xdata_in, ydata_in, zdata_in;
    logic [7:0]  fifo_data_in;
    logic [6:0]  FIFO_ENTRIES_in;
    logic        fifo_rd_en;
    logic [2:0]  HPF_CONER;
    logic [3:0]  ODR_LPF;
    logic        ACT_EN2, OVR_EN2, FULL_EN2, RDY_EN2, ACT_EN1, OVR_EN1, FULL_EN1, RDY_EN1;
    logic [1:0]  range;
    logic        DRDY_OFF, TEMP_OFF, STANDBY;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    int          pop_cnt;
    logic [2:0]  fifo_ptr;
    logic [7:0]  fifo_vals [8];

    always #5 mems_clk = ~mems_clk;

    adxl355_spi_regif #(.SYNC_STAGES(2)) dut (
        .mems_clk(mems_clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .NVM_BUSY(NVM_BUSY), .FIFO_OVR(FIFO_OVR), .temp_valid(temp_valid), .temp_in(temp_in),
        .xdata_valid(xdata_valid), .ydata_valid(ydata_valid), .zdata_valid(zdata_valid),
        .xdata_in(xdata_in), .ydata_in(ydata_in), .zdata_in(zdata_in),
        .fifo_data_in(fifo_data_in), .FIFO_ENTRIES_in(FIFO_ENTRIES_in), .fifo_rd_en(fifo_rd_en),
        .HPF_CONER(HPF_CONER), .ODR_LPF(ODR_LPF),
        .ACT_EN2(ACT_EN2), .OVR_EN2(OVR_EN2), .FULL_EN2(FULL_EN2), .RDY_EN2(RDY_EN2),
        .ACT_EN1(ACT_EN1), .OVR_EN1(OVR_EN1), .FULL_EN1(FULL_EN1), .RDY_EN1(RDY_EN1),
        .range(range), .DRDY_OFF(DRDY_OFF), .TEMP_OFF(TEMP_OFF), .STANDBY(STANDBY)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge mems_clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            wait_clk(6);
            sclk = 1'b1;
            wait_clk(6);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_end();
        wait_clk(6);
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clk(8);
    endtask

    task automatic write_reg(input logic [6:0] a, input logic [7:0] d);
        cs_begin();
        spi_bits({a, 1'b0}, 8);
        spi_bits(d, 8);
        cs_end();
    endtask

    task automatic read_regs(input logic [6:0] a, input int n);
        cs_begin();
        spi_bits({a, 1'b1}, 8);
        for (int i = 0; i < n; i++) spi_bits(8'h00, 8);
        cs_end();
    endtask

    // Decodes the bus independently of the host tasks and scores read bytes.
    task automatic monitor_loop();
        logic [7:0] sh_mosi, sh_miso, e;
        int nbit, nbyte;
        logic rw;
        nbit = 0; nbyte = 0; rw = 1'b0; sh_mosi = '0; sh_miso = '0;
        forever begin
            @(posedge sclk or posedge cs_n);
            if (cs_n) begin
                nbit = 0;
                nbyte = 0;
            end else begin
                sh_mosi = {sh_mosi[6:0], mosi};
                sh_miso = {sh_miso[6:0], miso};
                nbit++;
                if (nbit == 8) begin
                    nbit = 0;
                    if (nbyte == 0) begin
                        rw = sh_mosi[0];
                    end else if (rw) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL rd_byte: got 0x%02h, expected nothing queued", sh_miso);
                        end else begin
                            e = exp_q.pop_front();
                            chk("rd_byte", {24'h0, sh_miso}, {24'h0, e});
                        end
                    end
                    nbyte++;
                end
            end
        end
    endtask

    // FIFO head model: advances on every pop the DUT issues.
    task automatic fifo_model();
        forever begin
            @(negedge mems_clk);
            if (fifo_rd_en) begin
                pop_cnt++;
                fifo_ptr = fifo_ptr + 3'd1;
                fifo_data_in = fifo_vals[fifo_ptr];
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        NVM_BUSY = 1'b0; FIFO_OVR = 1'b0; temp_valid = 1'b0; temp_in = '0;
        xdata_valid = 1'b0; ydata_valid = 1'b0; zdata_valid = 1'b0;
        xdata_in = '0; ydata_in = '0; zdata_in = '0; FIFO_ENTRIES_in = '0;
        fifo_vals[0] = 8'h5A; fifo_vals[1] = 8'hC3; fifo_vals[2] = 8'h3C; fifo_vals[3] = 8'h99;
        fifo_vals[4] = 8'h11; fifo_vals[5] = 8'h22; fifo_vals[6] = 8'h33; fifo_vals[7] = 8'h44;
        fifo_ptr = 3'd0; pop_cnt = 0; fifo_data_in = fifo_vals[0];

        fork
            monitor_loop();
            fifo_model();
            begin
                #2_000_000;
                $display("FAIL timeout: simulation did not complete");
                failures++;
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1, "timeout");
            end
        join_none

        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(2);
        chk("rst_standby", 32'(STANDBY), 32'd1);
        chk("rst_range", 32'(range), 32'd1);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_filter", 32'({HPF_CONER, ODR_LPF}), 32'd0);
        chk("rst_int_map", 32'({ACT_EN2, OVR_EN2, FULL_EN2, RDY_EN2,
                                ACT_EN1, OVR_EN1, FULL_EN1, RDY_EN1}), 32'd0);
        chk("rst_pwr", 32'({DRDY_OFF, TEMP_OFF}), 32'd0);

        write_reg(7'h20, 8'hFF);
        exp_q.push_back(8'hFF); read_regs(7'h20, 1);
        exp_q.push_back(8'hAD); read_regs(7'h00, 1);
        write_reg(7'h00, 8'h12);
        exp_q.push_back(8'hAD); read_regs(7'h00, 1);
        exp_q.push_back(8'h00); read_regs(7'h30, 1);
        exp_q.push_back(8'h00); exp_q.push_back(8'hAD); read_regs(7'h7F, 2);

        cs_begin();
        spi_bits({7'h1E, 1'b0}, 8);
        for (int i = 1; i <= 17; i++) spi_bits(8'(i), 8);
        cs_end();
        chk("cfg_filter", 32'({HPF_CONER, ODR_LPF}), 32'h0B);
        chk("cfg_int_map", 32'({ACT_EN2, OVR_EN2, FULL_EN2, RDY_EN2,
                                ACT_EN1, OVR_EN1, FULL_EN1, RDY_EN1}), 32'h0D);
        chk("cfg_range", 32'(range), 32'h3);
        chk("cfg_power", 32'({DRDY_OFF, TEMP_OFF, STANDBY}), 32'h0);
        for (int i = 1; i <= 17; i++) exp_q.push_back(8'(i));
        read_regs(7'h1E, 17);

        pop_cnt = 0;
        exp_q.push_back(8'h5A); exp_q.push_back(8'hC3); exp_q.push_back(8'h3C);
        read_regs(7'h11, 3);
        chk("fifo_pops", 32'(pop_cnt), 32'd3);

        xdata_in = 20'hABCDE; NVM_BUSY = 1'b1; FIFO_ENTRIES_in = 7'd5;
        xdata_valid = 1'b1; wait_clk(1); xdata_valid = 1'b0;
        zdata_valid = 1'b1; wait_clk(1); zdata_valid = 1'b0;
        wait_clk(2);
        exp_q.push_back(8'h11); read_regs(7'h04, 1);
        exp_q.push_back(8'hAB); exp_q.push_back(8'hCD); exp_q.push_back(8'hE0);
        read_regs(7'h08, 3);
        FIFO_ENTRIES_in = 7'd12;
        exp_q.push_back(8'h12); exp_q.push_back(8'h0C); read_regs(7'h04, 2);
        FIFO_ENTRIES_in = 7'd11;
        exp_q.push_back(8'h10); read_regs(7'h04, 1);

        temp_in = 12'hABC;
        temp_valid = 1'b1; wait_clk(1); temp_valid = 1'b0;
        exp_q.push_back(8'h0A); exp_q.push_back(8'hBC); read_regs(7'h06, 2);

        cs_begin();
        spi_bits({7'h20, 1'b0}, 8);
        spi_bits(8'h55, 5);
        cs_end();
        exp_q.push_back(8'h03); read_regs(7'h20, 1);

        write_reg(7'h2D, 8'h00);
        chk("standby_cleared", 32'(STANDBY), 32'd0);
        write_reg(7'h2F, 8'h51);
        chk("soft_rst_ignored", 32'({STANDBY, range}), 32'b011);
        write_reg(7'h2F, 8'h52);
        chk("soft_rst_standby", 32'(STANDBY), 32'd1);
        chk("soft_rst_range", 32'(range), 32'd1);
        chk("soft_rst_filter", 32'({HPF_CONER, ODR_LPF}), 32'd0);
        exp_q.push_back(8'h81); exp_q.push_back(8'h01);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        read_regs(7'h2C, 4);

        wait_clk(4);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
